modport_slave: RTL and testbench
================================

Name: modport_slave

Overview:
- Jelly-bean "taster" slave. It is the responder on the jelly-bean bus and takes the slave side of that bus interface.
- It accepts recipe writes (flavor, color, sugar_free, sour), grades each recipe to a taste code, stores the last recipe and grade, and replays the grade on read.
- It sits below the bus master/driver as the register-style endpoint. Its statistics counters are visible to the checker.

Parameters:
- CNT_W, 8, width of the saturating statistics counters.

Ports:
- clk  input  1  bus clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flavor  input  3  0=NO_FLAVOR 1=APPLE 2=BLUEBERRY 3=BUBBLE_GUM 4=CHOCOLATE; 5-7 illegal.
- color  input  2  0=RED 1=GREEN 2=BLUE; 3 reserved, stored as-is.
- sugar_free  input  1  recipe attribute.
- sour  input  1  recipe attribute.
- command  input  2  0=NO_OP 1=READ 2=WRITE 3=reserved.
- taste  output  2  0=UNKNOWN 1=YUMMY 2=YUCKY (3 never driven).
- write_count  output  CNT_W  number of accepted WRITEs, saturating.
- yucky_count  output  CNT_W  number of WRITEs graded YUCKY, saturating.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. All state is sampled on posedge clk.
- The master drives inputs 1 ns after a posedge. The DUT samples them at the next posedge.
- Reset (rst=1 at a posedge):
  - taste=0, write_count=0, yucky_count=0.
  - Stored recipe registers and stored grade cleared to 0.
  - Reset overrides any command in the same cycle.
- Grading function, combinational on the sampled inputs:
  - flavor==NO_FLAVOR or flavor>4 -> UNKNOWN.
  - flavor==CHOCOLATE && sour==1 -> YUCKY.
  - Otherwise -> YUMMY.
  - color and sugar_free do not affect the grade.
- WRITE, at edge N:
  - Store flavor, color, sugar_free and sour.
  - Store the grade, and drive taste=grade, both registered at edge N.
  - write_count += 1.
  - yucky_count += 1 if the grade is YUCKY.
- READ, at edge N: taste=stored grade. No state change and no counter change.
- NO_OP or command=3, at edge N: taste=UNKNOWN. Stored state is held.
- Latency and hold: taste is a registered output with 1-cycle latency. It is valid from edge N until edge N+1, so the master samples it 1 ns before edge N+1. Every command cycle overwrites taste; there is no sticky output.
- Back-to-back commands are supported every cycle.
- READ directly after WRITE returns the new grade (the write takes effect at edge N; a read at N+1 sees it).
- READ before any WRITE returns UNKNOWN.
- Counters saturate at 2^CNT_W-1 and never wrap. At saturation a further write leaves the count unchanged.
- X or Z on command is treated as NO_OP. The implementation guards this with a case default.

Decomposition:
- Package jelly_bean_pkg holds:
  - enums flavor_e (3b), color_e (2b), command_e (2b), taste_e (2b);
  - the function grade(flavor, sour) returning taste_e;
  - the localparam CNT_W default.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated twice.
- The top module holds the recipe/grade registers and the command decode.

Test Plan:
- Reset: rst=1 for 2 cycles with command=WRITE, flavor=4, sour=1 -> taste=0, write_count=0, yucky_count=0 after reset.
- WRITE flavor=4 (CHOCOLATE), sour=1, color=2 -> taste=2 next cycle; yucky_count=1, write_count=1. A following READ -> taste=2.
- WRITE flavor=1 (APPLE), sour=1, sugar_free=1 -> taste=1. Then NO_OP -> taste=0. Then READ -> taste=1, and write_count is unchanged by the READ.
- WRITE flavor=0 and WRITE flavor=6 -> taste=0 for each; write_count increments by 2; yucky_count unchanged.
- Reset then READ with no prior WRITE -> taste=0. Command=3 -> taste=0 with no state change.
- Saturation with CNT_W=2: 5 consecutive WRITEs of flavor=4, sour=1 -> write_count=3 and yucky_count=3, held. Asserting rst mid-stream clears both to 0 on the next edge.

Source files
------------

// File: rtl/modport_slave_pkg.sv
// Shared types for the jelly-bean bus: recipe field encodings, the taste
// grading rule and the default statistics-counter width.
package jelly_bean_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    NO_FLAVOR  = 3'd0,
    APPLE      = 3'd1,
    BLUEBERRY  = 3'd2,
    BUBBLE_GUM = 3'd3,
    CHOCOLATE  = 3'd4
  } flavor_e;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_e;

  typedef enum logic [1:0] {
    NO_OP = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } command_e;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    YUMMY   = 2'd1,
    YUCKY   = 2'd2
  } taste_e;

  // Raw field widths are kept so illegal flavors and reserved colors survive storage.
  typedef struct packed {
    logic [2:0] flavor;
    logic [1:0] color;
    logic       sugar_free;
    logic       sour;
  } recipe_t;

  function automatic taste_e grade(input logic [2:0] flavor, input logic sour);
    if (flavor == NO_FLAVOR || flavor > CHOCOLATE) return UNKNOWN;
    if (flavor == CHOCOLATE && sour) return YUCKY;
    return YUMMY;
  endfunction

endpackage

// File: rtl/modport_slave_if.sv
// Jelly-bean bus: recipe fields and command from the master, taste back
// from the slave, plus the slave's copy of the last written recipe.
interface modport_slave_if;
  import jelly_bean_pkg::*;

  logic [2:0] flavor;
  logic [1:0] color;
  logic       sugar_free;
  logic       sour;
  logic [1:0] command;
  logic [1:0] taste;
  recipe_t    recipe;

  modport master (
    output flavor, color, sugar_free, sour, command,
    input  taste, recipe
  );

  modport slave (
    input  flavor, color, sugar_free, sour, command,
    output taste, recipe
  );

endinterface

// File: rtl/modport_slave_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/modport_slave.sv
// Jelly-bean taster: grades each written recipe, keeps the last recipe and
// grade, replays the grade on READ and counts writes / yucky writes.
module modport_slave
  import jelly_bean_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  modport_slave_if.slave   bus,
  output logic [CNT_W-1:0] write_count,
  output logic [CNT_W-1:0] yucky_count
);

  recipe_t recipe_q;
  taste_e  grade_q;
  taste_e  taste_q;
  taste_e  grade_d;
  logic    is_write;
  logic    is_yucky_write;

  // NOTE: every always_comb output is assigned on every path, so no latch can form.
  always_comb begin
    grade_d        = grade(bus.flavor, bus.sour);
    is_write       = (bus.command == WRITE);
    is_yucky_write = is_write && (grade_d == YUCKY);
  end

  // NOTE: the stored recipe is a handful of flops, not a RAM, so it takes the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      recipe_q <= '0;
      grade_q  <= UNKNOWN;
      taste_q  <= UNKNOWN;
    end else begin
      unique0 case (bus.command)
        WRITE: begin
          recipe_q <= '{flavor: bus.flavor, color: bus.color,
                        sugar_free: bus.sugar_free, sour: bus.sour};
          grade_q  <= grade_d;
          taste_q  <= grade_d;
        end
        READ:    taste_q <= grade_q;
        // NO_OP, reserved and unknown commands all answer UNKNOWN.
        default: taste_q <= UNKNOWN;
      endcase
    end
  end

  assign bus.taste  = taste_q;
  assign bus.recipe = recipe_q;

  sat_counter #(.W(CNT_W)) u_write_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (is_write),
    .count (write_count)
  );

  sat_counter #(.W(CNT_W)) u_yucky_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (is_yucky_write),
    .count (yucky_count)
  );

endmodule

// File: tb/tb_modport_slave.sv
// Random and directed stimulus on two tasters (8-bit and 2-bit counters)
// checked against a behavioural model of the grading and counting rules.
module tb_modport_slave;
  import jelly_bean_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modport_slave_if bus8 ();
  modport_slave_if bus2 ();

  logic [7:0] wc8, yc8;
  logic [1:0] wc2, yc2;

  modport_slave #(.CNT_W(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus8),
    .write_count (wc8),
    .yucky_count (yc8)
  );

  modport_slave #(.CNT_W(2)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus2),
    .write_count (wc2),
    .yucky_count (yc2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain integers, saturation applied only when compared.
  int exp_taste    = 0;
  int stored_grade = 0;
  int writes       = 0;
  int yuckies      = 0;
  int exp_recipe   = 0;

  function automatic int ref_grade(input int f, input int s);
    if (f == 0 || f > 4) return 0;
    if (f == 4 && s == 1) return 2;
    return 1;
  endfunction

  function automatic int cap(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input int cmd, input int f, input int c,
                       input int sf, input int so);
    int g;
    rst             = r;
    bus8.command    = 2'(cmd);
    bus8.flavor     = 3'(f);
    bus8.color      = 2'(c);
    bus8.sugar_free = 1'(sf);
    bus8.sour       = 1'(so);
    bus2.command    = 2'(cmd);
    bus2.flavor     = 3'(f);
    bus2.color      = 2'(c);
    bus2.sugar_free = 1'(sf);
    bus2.sour       = 1'(so);

    if (r) begin
      exp_taste = 0; stored_grade = 0; writes = 0; yuckies = 0; exp_recipe = 0;
    end else if (cmd == 2) begin
      g            = ref_grade(f, so);
      stored_grade = g;
      exp_taste    = g;
      exp_recipe   = f * 16 + c * 4 + sf * 2 + so;
      writes++;
      if (g == 2) yuckies++;
    end else if (cmd == 1) begin
      exp_taste = stored_grade;
    end else begin
      exp_taste = 0;
    end

    @(posedge clk);
    #1;
    check("taste8",  int'(bus8.taste),  exp_taste);
    check("taste2",  int'(bus2.taste),  exp_taste);
    check("recipe8", int'(bus8.recipe), exp_recipe);
    check("wcnt8",   int'(wc8), cap(writes, 255));
    check("ycnt8",   int'(yc8), cap(yuckies, 255));
    check("wcnt2",   int'(wc2), cap(writes, 3));
    check("ycnt2",   int'(yc2), cap(yuckies, 3));
  endtask

  initial begin
    bus8.command = 2'd0; bus8.flavor = 3'd0; bus8.color = 2'd0;
    bus8.sugar_free = 1'b0; bus8.sour = 1'b0;
    bus2.command = 2'd0; bus2.flavor = 3'd0; bus2.color = 2'd0;
    bus2.sugar_free = 1'b0; bus2.sour = 1'b0;

    // Reset beats a simultaneous yucky WRITE.
    cycle(1, 2, 4, 0, 0, 1);
    cycle(1, 2, 4, 0, 0, 1);

    // Yucky chocolate, then read it back.
    cycle(0, 2, 4, 2, 0, 1);
    cycle(0, 1, 0, 0, 0, 0);

    // Yummy apple, NO_OP clears taste, READ replays it.
    cycle(0, 2, 1, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);

    // Unknown flavors: no flavor and an illegal code.
    cycle(0, 2, 0, 1, 0, 0);
    cycle(0, 2, 6, 3, 1, 1);

    // READ with no prior WRITE, then the reserved command.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 3, 2, 1, 0, 1);

    // Drive the 2-bit counters into saturation, then reset mid-stream.
    for (int i = 0; i < 5; i++) cycle(0, 2, 4, 0, 0, 1);
    cycle(1, 2, 4, 0, 0, 1);
    cycle(0, 2, 3, 1, 1, 0);

    // Random traffic with occasional resets; writes dominate to reach saturation.
    for (int i = 0; i < 600; i++) begin
      int cmd;
      int pick;
      pick = int'($urandom_range(0, 9));
      cmd  = (pick < 5) ? 2 : (pick < 8) ? 1 : (pick == 8) ? 0 : 3;
      cycle(($urandom_range(0, 99) == 0), cmd,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
